// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: feeds one operand bit pair per clock (LSB first) into a
// single full-adder cell, recirculates its carry and assembles the sum word.

// One-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cy_in,
  output logic s,
  output logic cy_out
);
  assign s      = a ^ b ^ cy_in;
  assign cy_out = (a & b) | (cy_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, ps, sum_q;
  logic             cy, cout_q;
  logic [CW-1:0]    cnt;
  logic             fs, fc;
  logic             accept, last;

  full_adder u_fa (
    .a      (sa[0]),
    .b      (sb[0]),
    .cy_in  (cy),
    .s      (fs),
    .cy_out (fc)
  );

  // start is only honoured outside RUN; the final bit is processed when cnt hits WIDTH-1.
  assign accept = bus.start && (state_q != RUN);
  assign last   = (state_q == RUN) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; IDLE and DONE both accept a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand load, per-bit shift/carry update, and result capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      ps     <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      cy  <= bus.cin;
      cnt <= '0;
    end else if (state_q == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      cy  <= fc;
      ps  <= {fs, ps[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (last) begin
        sum_q  <= {fs, ps[WIDTH-1:1]};
        cout_q <= fc;
      end
    end
  end

  // Status decodes straight off the state flops, so no input reaches an output combinationally.
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and sweep bench for serial_adder at WIDTH=4 and WIDTH=8.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   dcnt4 = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(4)) i4 ();
  serial_adder_if #(.WIDTH(8)) i8 ();

  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  // Count done cycles of the 4-bit unit (pre-edge value at each rising edge).
  always @(posedge clk) if (i4.done) dcnt4++;

  // Run one 4-bit add; returns busy cycle count, busy&done overlap and timeout flags, result.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output int bc, output logic both, output logic to,
                        output logic [3:0] s, output logic c);
    @(negedge clk);
    i4.start = 1'b1; i4.a = a; i4.b = b; i4.cin = cin;
    @(negedge clk);
    i4.start = 1'b0; i4.a = 4'($urandom); i4.b = 4'($urandom); i4.cin = 1'($urandom);
    bc = 0; both = 1'b0; to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (i4.busy && i4.done) both = 1'b1;
      if (i4.done) begin to = 1'b0; break; end
      if (i4.busy) bc++;
      @(negedge clk);
    end
    s = i4.sum; c = i4.cout;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int bc, output logic both, output logic to,
                        output logic [7:0] s, output logic c);
    @(negedge clk);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.cin = cin;
    @(negedge clk);
    i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom); i8.cin = 1'($urandom);
    bc = 0; both = 1'b0; to = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (i8.busy && i8.done) both = 1'b1;
      if (i8.done) begin to = 1'b0; break; end
      if (i8.busy) bc++;
      @(negedge clk);
    end
    s = i8.sum; c = i8.cout;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({i4.busy, i4.done, i4.sum, i4.cout} !== 7'b0) begin
      errors++; $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b, want all 0", i4.busy, i4.done, i4.sum, i4.cout);
    end
    checks++;
    if ({i8.busy, i8.done, i8.sum, i8.cout} !== 11'b0) begin
      errors++; $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b, want all 0", i8.busy, i8.done, i8.sum, i8.cout);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int bc; logic both, to, c; logic [3:0] s;
    do_op4(4'h5, 4'h2, 1'b0, bc, both, to, s, c);
    checks++;
    if (to || both || bc != 4) begin
      errors++; $display("FAIL basic_timing: busy_cycles=%0d overlap=%b timeout=%b, want 4/0/0", bc, both, to);
    end
    checks++;
    if ({c, s} !== 5'h07) begin
      errors++; $display("FAIL basic_sum: got cout=%b sum=%h, want 0/7", c, s);
    end
    @(negedge clk);
    checks++;
    if (i4.done !== 1'b0 || i4.busy !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: done=%b busy=%b one cycle after done, want 0/0", i4.done, i4.busy);
    end
  endtask

  task automatic test_overflow;
    int bc; logic both, to, c; logic [3:0] s;
    do_op4(4'h7, 4'h9, 1'b0, bc, both, to, s, c);
    checks++;
    if (to || {c, s} !== 5'h10) begin
      errors++; $display("FAIL ovf_7_9: got cout=%b sum=%h timeout=%b, want 1/0", c, s, to);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({i4.cout, i4.sum} !== 5'h10 || i4.busy !== 1'b0) begin
      errors++; $display("FAIL ovf_hold1: got cout=%b sum=%h busy=%b, want 1/0/0", i4.cout, i4.sum, i4.busy);
    end
    do_op4(4'hF, 4'hF, 1'b1, bc, both, to, s, c);
    checks++;
    if (to || {c, s} !== 5'h1F) begin
      errors++; $display("FAIL ovf_f_f_1: got cout=%b sum=%h timeout=%b, want 1/f", c, s, to);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({i4.cout, i4.sum} !== 5'h1F) begin
      errors++; $display("FAIL ovf_hold2: got cout=%b sum=%h, want 1/f", i4.cout, i4.sum);
    end
  endtask

  task automatic test_ignored_start;
    int d0; logic to;
    d0 = dcnt4;
    @(negedge clk);
    i4.start = 1'b1; i4.a = 4'h6; i4.b = 4'h5; i4.cin = 1'b0;
    @(negedge clk);                       // RUN cycle 1
    i4.start = 1'b0;
    @(negedge clk);                       // RUN cycle 2
    i4.start = 1'b1; i4.a = 4'h1; i4.b = 4'h1;
    @(negedge clk);
    i4.start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (i4.done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++;
    if (to || {i4.cout, i4.sum} !== 5'h0B) begin
      errors++; $display("FAIL ign_sum: got cout=%b sum=%h timeout=%b, want 0/b", i4.cout, i4.sum, to);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (dcnt4 - d0 != 1 || i4.busy !== 1'b0 || {i4.cout, i4.sum} !== 5'h0B) begin
      errors++; $display("FAIL ign_single: done_pulses=%0d busy=%b sum=%h, want 1/0/b", dcnt4 - d0, i4.busy, i4.sum);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] va [4] = '{4'h3, 4'h8, 4'hA, 4'h2};
    logic [3:0] vb [4] = '{4'h4, 4'h8, 4'h5, 4'h2};
    logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] ve [4] = '{5'h07, 5'h10, 5'h10, 5'h05};
    int k;
    @(negedge clk);
    i4.start = 1'b1; i4.a = va[0]; i4.b = vb[0]; i4.cin = vc[0];
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!i4.done && k < 20);
      if (i < 3) begin
        i4.a = va[i+1]; i4.b = vb[i+1]; i4.cin = vc[i+1];
      end else begin
        i4.start = 1'b0;
      end
      checks++;
      if (k != 5 || {i4.cout, i4.sum} !== ve[i]) begin
        errors++; $display("FAIL b2b_%0d: period=%0d cout=%b sum=%h, want 5/%h", i, k, i4.cout, i4.sum, ve[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (i4.busy !== 1'b0 || i4.done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b done=%b, want 0/0", i4.busy, i4.done);
    end
  endtask

  task automatic test_reset_mid;
    int d0, bc; logic both, to, c; logic [3:0] s;
    @(negedge clk);
    i4.start = 1'b1; i4.a = 4'h9; i4.b = 4'h3; i4.cin = 1'b0;
    @(negedge clk);
    i4.start = 1'b0;
    @(negedge clk);                       // RUN cycle 2
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({i4.busy, i4.done, i4.sum, i4.cout} !== 7'b0) begin
      errors++; $display("FAIL rstmid_async: busy=%b done=%b sum=%h cout=%b, want all 0", i4.busy, i4.done, i4.sum, i4.cout);
    end
    d0 = dcnt4;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (dcnt4 != d0 || i4.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_nodone: done_pulses=%0d busy=%b, want 0/0", dcnt4 - d0, i4.busy);
    end
    do_op4(4'h3, 4'h4, 1'b0, bc, both, to, s, c);
    checks++;
    if (to || bc != 4 || {c, s} !== 5'h07) begin
      errors++; $display("FAIL rstmid_fresh: busy_cycles=%0d cout=%b sum=%h, want 4/0/7", bc, c, s);
    end
  endtask

  task automatic test_exhaustive4;
    int bc; logic both, to, c; logic [3:0] s; logic [4:0] e;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int ci = 0; ci < 2; ci++) begin
          e = 5'(x + y + ci);
          do_op4(4'(x), 4'(y), 1'(ci), bc, both, to, s, c);
          checks++;
          if (to || both || bc != 4 || {c, s} !== e) begin
            errors++; $display("FAIL exh4 %h+%h+%0d: got cout=%b sum=%h busy_cycles=%0d overlap=%b timeout=%b, want %h/4",
                               x, y, ci, c, s, bc, both, to, e);
          end
        end
  endtask

  task automatic test_random8;
    int bc; logic both, to, c; logic [7:0] s, x, y; logic ci; logic [8:0] e;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom);
      if (n == 0) begin x = 8'hFF; y = 8'hFF; ci = 1'b1; end
      if (n == 1) begin x = 8'h00; y = 8'h00; ci = 1'b0; end
      e = 9'(x) + 9'(y) + 9'(ci);
      do_op8(x, y, ci, bc, both, to, s, c);
      checks++;
      if (to || both || bc != 8 || {c, s} !== e) begin
        errors++; $display("FAIL rnd8 %h+%h+%b: got cout=%b sum=%h busy_cycles=%0d overlap=%b timeout=%b, want %h/8",
                           x, y, ci, c, s, bc, both, to, e);
      end
    end
  endtask

  initial begin
    i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.cin = 1'b0;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    test_random8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that produces the WIDTH-bit sum of two operands plus a carry-in. It sits directly upstream of the existing one-bit full-adder cell (sum = a^b^cy_in, cy_out = a&b | cy_in&(a^b)) and drives it with one operand bit pair per clock, LSB first. It registers that cell's carry between cycles and assembles its sum bits into a result word. It trades WIDTH cycles of latency for a single adder cell, and presents a start/busy/done handshake to the surrounding datapath.

## Interface
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on a rising edge only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high while in DONE.
- sum  output  WIDTH  result register; (a+b+cin) mod 2^WIDTH.
- cout  output  1  result carry-out; bit WIDTH of a+b+cin.

## Operation
- Internal state:
  - operand shift registers sa and sb, WIDTH bits each.
  - carry flop cy.
  - partial-sum shift register ps, WIDTH bits.
  - bit counter cnt, width max(1, $clog2(WIDTH)).
  - state register.
- The full-adder cell is instantiated once with inputs sa[0], sb[0] and cy. Its outputs are fs and fc.
- States and transitions:
  - IDLE: busy=0, done=0. If start=1, load sa<=a, sb<=b, cy<=cin, cnt<=0, and go to RUN. Otherwise stay in IDLE.
  - RUN: busy=1. Each edge performs: sa<=sa>>1; sb<=sb>>1; cy<=fc; ps<={fs, ps[WIDTH-1:1]}; cnt<=cnt+1.
  - RUN exit: on the edge where cnt==WIDTH-1, also load sum<={fs, ps[WIDTH-1:1]} and cout<=fc, then go to DONE.
  - DONE: done=1, busy=0. If start=1, load new operands exactly as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
- start in RUN is ignored. It is not queued, and the a, b and cin inputs are not sampled.
- sum and cout change only on the final RUN edge. They hold the previous result throughout RUN and indefinitely in IDLE.
- Arithmetic is unsigned. Overflow is reported only through cout; there is no wrap flag.
- Operand inputs may change freely at any time other than the accepting edge.

## Timing
- Reset (rst_n=0, asynchronous, immediate) sets:
  - state to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - sa, sb, ps, cy and cnt to 0.
- Reset mid-RUN aborts the operation, and no done pulse is produced.
- Reset release: the first rising edge with rst_n=1 may accept start.
- Latency: start accepted at edge E gives busy=1 from E to E+WIDTH. sum/cout are valid and done=1 from E+WIDTH to E+WIDTH+1.
- Throughput: one result every WIDTH+1 cycles with start held high continuously.
- done is high for exactly one cycle per accepted start. busy and done are never high together.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Basic add, WIDTH=4: a=4'h5, b=4'h2, cin=0, start pulsed for 1 cycle. Required: busy high for 4 cycles, then done for 1 cycle, with sum=4'h7 and cout=0.
- Carry chain and overflow: a=4'h7, b=4'h9, cin=0 gives sum=4'h0, cout=1. a=4'hF, b=4'hF, cin=1 gives sum=4'hF, cout=1. Both results are held in IDLE afterwards.
- Ignored start: start pulsed during cycle 2 of RUN with a=4'h1, b=4'h1. Required: the original result is unchanged, exactly one done pulse, and the FSM returns to IDLE.
- Back-to-back: start held high with a new operand pair presented in the DONE cycle. Required: the next RUN begins immediately, done pulses every 5 cycles, and each sum matches its own operands.
- Reset mid-operation: rst_n driven low asynchronously in RUN cycle 2. Required:
  - busy, done, sum and cout go to 0 immediately, with no done pulse.
  - After release, a fresh add of 4'h3+4'h4 gives sum 4'h7.
- Exhaustive, WIDTH=4 and WIDTH=8 (random 1000 for WIDTH=8): all a, b and cin combinations compared against a+b+cin in a reference model. Required: both sum and cout match, and done/busy timing is checked every transaction.
